// File: rtl/trng_bit_packer.sv
`timescale 1ns/1ps
// Samples the ring-generator bit stream, runs a repetition-count health test and packs
// accepted bits (MSB oldest) into words on a valid/ready port. Define TRNG_VN_DEBIAS_EN for Von Neumann debiasing.
module trng_bit_packer #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned SAMPLE_DIV = 4,
  parameter int unsigned REP_LIMIT  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              bit_in,
  input  logic              clr_fail,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              health_fail,
  output logic [15:0]       word_cnt
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(WORD_W);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_W - 1);
  localparam logic [7:0]       REP_LAST  = 8'(REP_LIMIT);

  typedef enum logic [0:0] {
    ST_COLLECT,
    ST_PEND
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [7:0]        rep_q, rep_d;
  logic              prev_q, prev_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              fail_q, fail_d;
  logic [15:0]       wcnt_q, wcnt_d;

  logic              xfer;
  logic              sample_en;
  logic              release_word;
  logic              strobe;
  logic [7:0]        rep_next;
  logic              trip;
  logic              block;
  logic              acc_valid;
  logic              acc_bit;
  logic [WORD_W-1:0] word_full;
  logic              word_done;
  logic              load_new;
  logic              hold_word;

`ifdef TRNG_VN_DEBIAS_EN
  logic vn_have_q, vn_have_d;
  logic vn_first_q, vn_first_d;
`endif

  assign xfer = valid_q & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a completed word that cannot reach the slot parks the collector
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_COLLECT: if (en && hold_word) state_d = ST_PEND;
      ST_PEND:    if (!en || fail_q || xfer) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // State outputs
  always_comb begin
    sample_en    = 1'b0;
    release_word = 1'b0;
    unique case (state_q)
      ST_COLLECT: sample_en    = en;
      ST_PEND:    release_word = en & xfer;
      default:    ;
    endcase
  end

  assign strobe = sample_en & (div_q == DIV_LAST);

  // Repetition-count health test on raw samples
  always_comb begin
    rep_next = rep_q;
    if (strobe) begin
      if ((rep_q == 8'd0) || (bit_in != prev_q)) begin
        rep_next = 8'd1;
      end else if (rep_q != 8'hFF) begin
        rep_next = rep_q + 8'd1;
      end
    end
  end

  assign trip   = strobe & (rep_next == REP_LAST);
  assign block  = fail_q | trip;
  assign fail_d = trip | (fail_q & ~clr_fail);
  assign prev_d = strobe ? bit_in : prev_q;

  always_comb begin
    rep_d = rep_next;
    if (!en || clr_fail) begin
      rep_d = '0;
    end
  end

`ifdef TRNG_VN_DEBIAS_EN
  // Von Neumann pairing: 10 -> 1, 01 -> 0, equal pairs dropped
  assign acc_valid = strobe & ~block & vn_have_q & (vn_first_q != bit_in);
  assign acc_bit   = vn_first_q;

  always_comb begin
    vn_have_d  = vn_have_q;
    vn_first_d = vn_first_q;
    if (!en || block) begin
      vn_have_d = 1'b0;
    end else if (strobe) begin
      vn_have_d = ~vn_have_q;
      if (!vn_have_q) begin
        vn_first_d = bit_in;
      end
    end
  end
`else
  assign acc_valid = strobe & ~block;
  assign acc_bit   = bit_in;
`endif

  assign word_full = {shreg_q[WORD_W-2:0], acc_bit};
  assign word_done = acc_valid & (bcnt_q == WORD_LAST);
  assign load_new  = word_done & (~valid_q | out_ready);
  assign hold_word = word_done & valid_q & ~out_ready;

  // Divider holds its count while a word is parked
  always_comb begin
    div_d = div_q;
    if (!en) begin
      div_d = '0;
    end else if (sample_en) begin
      div_d = strobe ? '0 : div_q + DIV_W'(1);
    end
  end

  always_comb begin
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    if (!en || block || release_word) begin
      shreg_d = '0;
      bcnt_d  = '0;
    end else if (acc_valid) begin
      if (word_done) begin
        shreg_d = load_new ? '0 : word_full;
        bcnt_d  = '0;
      end else begin
        shreg_d = word_full;
        bcnt_d  = bcnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~xfer;
    if (load_new) begin
      data_d  = word_full;
      valid_d = 1'b1;
    end else if (release_word) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
    end
  end

  assign wcnt_d = wcnt_q + 16'(xfer);

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q   <= '0;
      shreg_q <= '0;
      bcnt_q  <= '0;
      rep_q   <= '0;
      prev_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fail_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      div_q   <= div_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      rep_q   <= rep_d;
      prev_q  <= prev_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fail_q  <= fail_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef TRNG_VN_DEBIAS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      vn_have_q  <= 1'b0;
      vn_first_q <= 1'b0;
    end else begin
      vn_have_q  <= vn_have_d;
      vn_first_q <= vn_first_d;
    end
  end
`endif

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign health_fail = fail_q;
  assign word_cnt    = wcnt_q;

endmodule

// File: tb/tb_trng_bit_packer.sv
`timescale 1ns/1ps
// Drives two packers (sample divider 1 and 4) with shared inputs and compares them every
// cycle against a word-level reference model, plus directed timing points.
module tb_trng_bit_packer;

  localparam int W   = 32;
  localparam int REP = 32;
`ifdef TRNG_VN_DEBIAS_EN
  localparam bit VN = 1'b1;
`else
  localparam bit VN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, bit_in, clr_fail, out_ready;
  logic [W-1:0] d1_data, d4_data;
  logic d1_valid, d4_valid, d1_hf, d4_hf;
  logic [15:0] d1_wc, d4_wc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trng_bit_packer #(.WORD_W(W), .SAMPLE_DIV(1), .REP_LIMIT(REP)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr_fail(clr_fail),
    .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
    .health_fail(d1_hf), .word_cnt(d1_wc)
  );

  trng_bit_packer #(.WORD_W(W), .SAMPLE_DIV(4), .REP_LIMIT(REP)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr_fail(clr_fail),
    .out_data(d4_data), .out_valid(d4_valid), .out_ready(out_ready),
    .health_fail(d4_hf), .word_cnt(d4_wc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state, index 0 = divider 1, index 1 = divider 4
  int     divs[2] = '{1, 4};
  int     divc[2];
  longint acc[2];
  int     nb[2];
  bit     pend[2];
  longint pw[2];
  bit     mv[2];
  longint md[2];
  bit     mf[2];
  int     rep[2];
  bit     prev[2];
  int     wc[2];
  bit     pair_has[2];
  bit     pair_first[2];

  task automatic model_step(input int m);
    bit xfer, load, strobe, trip, got, b;
    longint ldw;
    if (!rst) begin
      divc[m] = 0; acc[m] = 0; nb[m] = 0; pend[m] = 0; pw[m] = 0;
      mv[m] = 0; md[m] = 0; mf[m] = 0; rep[m] = 0; prev[m] = 0;
      wc[m] = 0; pair_has[m] = 0; pair_first[m] = 0;
      return;
    end
    xfer = mv[m] && out_ready;
    load = 0; ldw = 0; trip = 0; got = 0; b = 0;
    if (!en) begin
      divc[m] = 0; acc[m] = 0; nb[m] = 0; pend[m] = 0; pair_has[m] = 0; rep[m] = 0;
    end else if (pend[m]) begin
      if (xfer) begin
        load = 1; ldw = pw[m]; pend[m] = 0;
      end
    end else begin
      strobe = (divc[m] == divs[m] - 1);
      divc[m] = strobe ? 0 : divc[m] + 1;
      if (strobe) begin
        if (rep[m] == 0 || bit_in != prev[m]) rep[m] = 1;
        else if (rep[m] < 255) rep[m]++;
        prev[m] = bit_in;
        trip = (rep[m] == REP);
        if (!mf[m] && !trip) begin
          if (VN) begin
            if (!pair_has[m]) begin
              pair_first[m] = bit_in; pair_has[m] = 1;
            end else begin
              pair_has[m] = 0;
              if (pair_first[m] != bit_in) begin got = 1; b = pair_first[m]; end
            end
          end else begin
            got = 1; b = bit_in;
          end
        end
        if (got) begin
          acc[m] = acc[m] * 2 + longint'(b);
          nb[m]++;
          if (nb[m] == W) begin
            if (!mv[m] || out_ready) begin load = 1; ldw = acc[m]; end
            else begin pend[m] = 1; pw[m] = acc[m]; end
            acc[m] = 0; nb[m] = 0;
          end
        end
      end
      if (mf[m] || trip) begin acc[m] = 0; nb[m] = 0; pair_has[m] = 0; end
    end
    if (clr_fail) rep[m] = 0;
    mf[m] = trip || (mf[m] && !clr_fail);
    if (load) begin md[m] = ldw; mv[m] = 1; end
    else if (xfer) mv[m] = 0;
    if (xfer) wc[m] = (wc[m] + 1) % 65536;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    check("d1.valid", 64'(d1_valid), 64'(mv[0]));
    check("d1.data",  64'(d1_data),  md[0]);
    check("d1.fail",  64'(d1_hf),    64'(mf[0]));
    check("d1.wcnt",  64'(d1_wc),    64'(wc[0]));
    check("d4.valid", 64'(d4_valid), 64'(mv[1]));
    check("d4.data",  64'(d4_data),  md[1]);
    check("d4.fail",  64'(d4_hf),    64'(mf[1]));
    check("d4.wcnt",  64'(d4_wc),    64'(wc[1]));
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; bit_in = 1'b0; clr_fail = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1; en = 1'b1;
  endtask

  initial begin
    int runlen;
    bit [7:0] pat;
    do_reset();
    check("rst.valid", 64'(d1_valid), 64'd0);
    check("rst.wcnt",  64'(d4_wc),    64'd0);

    // Repetition-count trip with a constant stream
    out_ready = 1'b1; bit_in = 1'b1;
    for (int k = 0; k < 130; k++) begin
      tick();
      if (k == 30)  check("hf1.pre",  64'(d1_hf), 64'd0);
      if (k == 31)  check("hf1.trip", 64'(d1_hf), 64'd1);
      if (k == 126) check("hf4.pre",  64'(d4_hf), 64'd0);
      if (k == 127) check("hf4.trip", 64'(d4_hf), 64'd1);
    end
    check("hf.novalid", 64'(d1_valid), 64'd0);
    check("hf.nowc",    64'(d1_wc),    64'd0);
    clr_fail = 1'b1; bit_in = 1'b0;
    tick();
    check("hf1.clr", 64'(d1_hf), 64'd0);
    clr_fail = 1'b0;
`ifndef TRNG_VN_DEBIAS_EN
    for (int j = 0; j < 32; j++) begin
      bit_in = (j % 2 == 0);
      tick();
      if (j == 30) check("clr.restart.pre", 64'(d1_valid), 64'd0);
      if (j == 31) begin
        check("clr.restart.valid", 64'(d1_valid), 64'd1);
        check("clr.restart.data",  64'(d1_data),  64'hAAAAAAAA);
      end
    end

    // Divider 1, zero-bubble streaming
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 65; k++) begin
      bit_in = (k % 2 == 0);
      tick();
      if (k == 30) check("s1.pre",    64'(d1_valid), 64'd0);
      if (k == 31) check("s1.word1",  64'(d1_data),  64'hAAAAAAAA);
      if (k == 31) check("s1.valid1", 64'(d1_valid), 64'd1);
      if (k == 62) check("s1.gap",    64'(d1_valid), 64'd0);
      if (k == 63) check("s1.word2",  64'(d1_data),  64'hAAAAAAAA);
      if (k == 64) check("s1.wcnt",   64'(d1_wc),    64'd2);
    end

    // Divider 4, back-pressure and pending word
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 280; k++) begin
      bit_in = ((k / 4) % 2 == 0);
      tick();
      if (k == 126) check("s4.pre",   64'(d4_valid), 64'd0);
      if (k == 127) check("s4.valid", 64'(d4_valid), 64'd1);
      if (k == 127) check("s4.data",  64'(d4_data),  64'hAAAAAAAA);
    end
    check("s4.held", 64'(d4_wc), 64'd0);
    out_ready = 1'b1;
    tick();
    check("s4.rel.wcnt",  64'(d4_wc),    64'd1);
    check("s4.rel.valid", 64'(d4_valid), 64'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bit_in = ((k / 4) % 2 == 0);
      tick();
    end

    // Reset mid-word with a word waiting in the slot
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 52; k++) begin
      bit_in = (k % 2 == 0);
      tick();
    end
    check("mid.valid.before", 64'(d1_valid), 64'd1);
    rst = 1'b0;
    tick();
    check("mid.rst.data",  64'(d1_data),  64'd0);
    check("mid.rst.valid", 64'(d1_valid), 64'd0);
    check("mid.rst.fail",  64'(d1_hf),    64'd0);
    check("mid.rst.wcnt",  64'(d1_wc),    64'd0);
    rst = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < 32; j++) begin
      bit_in = (j % 2 == 0);
      tick();
      if (j == 30) check("mid.full.pre",  64'(d1_valid), 64'd0);
      if (j == 31) check("mid.full.data", 64'(d1_data),  64'hAAAAAAAA);
    end

    // Enable dropped for one cycle mid-word
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 42; k++) begin
      bit_in = (k < 32) ? (k % 2 == 0) : 1'b1;
      tick();
    end
    en = 1'b0;
    tick();
    check("en.keep.valid", 64'(d1_valid), 64'd1);
    check("en.keep.data",  64'(d1_data),  64'hAAAAAAAA);
    en = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < 32; j++) begin
      bit_in = (j % 4 < 2);
      tick();
      if (j == 30) check("en.new.pre",  64'(d1_valid), 64'd0);
      if (j == 31) check("en.new.data", 64'(d1_data),  64'hCCCCCCCC);
    end
`else
    // Von Neumann corrector on a fixed raw pattern
    do_reset();
    out_ready = 1'b1;
    pat = 8'b1001_1100;
    for (int k = 0; k < 128; k++) begin
      bit_in = pat[7 - (k % 8)];
      tick();
      if (k == 126) check("vn.pre",   64'(d1_valid), 64'd0);
      if (k == 127) check("vn.valid", 64'(d1_valid), 64'd1);
      if (k == 127) check("vn.data",  64'(d1_data),  64'hAAAAAAAA);
    end
`endif

    // Randomized traffic with runs, stalls, enable drops, clears and resets
    do_reset();
    runlen = 0;
    for (int k = 0; k < 6000; k++) begin
      if (runlen > 0) runlen--;
      else begin
        bit_in = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 149) == 0) runlen = int'($urandom_range(20, 40));
      end
      out_ready = ($urandom_range(0, 3) != 0) && (k % 500 < 400);
      en        = ($urandom_range(0, 299) != 0);
      clr_fail  = ($urandom_range(0, 59) == 0);
      rst       = ($urandom_range(0, 1999) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
